// File: rtl/wb_led_sequencer_pkg.sv
// Shared types for the LED sequencer: pattern mode encodings and bus FSM states.
package wb_led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/seq_button_filter.sv
// Button conditioning: 2-flop synchronizer, optional debounce, rising-edge press pulse.
// Debounce filter is built only when SEQ_DEBOUNCE_EN is defined.
module seq_button_filter #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic press_o
);

`ifdef SEQ_DEBOUNCE_EN
  localparam bit DebounceEn = 1'b1;
`else
  localparam bit DebounceEn = 1'b0;
`endif

  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  // A zero cycle count degenerates to the plain edge detector.
  if (DebounceEn && (DEBOUNCE_CYCLES != 16'd0)) begin : g_debounce
    logic [15:0] stable_q, stable_d;
    logic        filt_q, filt_d;
    logic        prev_q;

    always_comb begin
      stable_d = stable_q;
      filt_d   = filt_q;
      if (sync2_q == filt_q) begin
        stable_d = '0;
      end else if (stable_q == DEBOUNCE_CYCLES - 16'd1) begin
        filt_d   = sync2_q;
        stable_d = '0;
      end else begin
        stable_d = stable_q + 16'd1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stable_q <= '0;
        filt_q   <= 1'b0;
        prev_q   <= 1'b0;
      end else begin
        stable_q <= stable_d;
        filt_q   <= filt_d;
        prev_q   <= filt_q;
      end
    end

    assign press_o = filt_q & ~prev_q;
  end else begin : g_plain
    logic prev_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) prev_q <= 1'b0;
      else       prev_q <= sync2_q;
    end

    assign press_o = sync2_q & ~prev_q;
  end

endmodule

// File: rtl/wb_led_sequencer.sv
// Wishbone classic master that periodically writes LED animation patterns.
// Optional button debounce is enabled with SEQ_DEBOUNCE_EN.
module wb_led_sequencer
  import wb_led_sequencer_pkg::*;
#(
  parameter int unsigned LED_BITS        = 12,
  parameter int unsigned PERIOD_W        = 24,
  parameter logic [31:0] LED_ADDR        = 32'h3000_0000,
  parameter int unsigned TIMEOUT         = 255,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_button,
  input  logic [1:0]          i_mode,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [31:0]         o_wb_addr,
  output logic [31:0]         o_wb_data,
  input  logic                i_wb_ack,
  output logic                o_running,
  output logic                o_err,
  output logic [LED_BITS-1:0] o_last
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [LED_BITS-1:0] PAT_ALT = LED_BITS'({LED_BITS{2'b01}});

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [LED_BITS-1:0] pat_q, pat_d, pat_nxt, pat_init;
  logic                dir_up_q, dir_up_d, dir_nxt;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_m1;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic [LED_BITS-1:0] last_q, last_d;
  logic                press;
  logic                stop_ev;

  seq_button_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clk_i   (clk),
    .rst_i   (reset),
    .button_i(i_button),
    .press_o (press)
  );

  assign stop_ev   = i_stop || (press && (state_q != IDLE));
  assign period_m1 = (i_period == '0) ? '0 : i_period - PERIOD_W'(1);

  always_comb begin
    unique case (mode_e'(i_mode))
      MODE_COUNT:  pat_init = '0;
      MODE_TOGGLE: pat_init = PAT_ALT;
      default:     pat_init = LED_BITS'(1);
    endcase
  end

  // Bounce keeps a direction bit so the end positions are not repeated.
  always_comb begin
    pat_nxt = pat_q;
    dir_nxt = dir_up_q;
    unique case (mode_q)
      MODE_WALK:   pat_nxt = {pat_q[LED_BITS-2:0], pat_q[LED_BITS-1]};
      MODE_COUNT:  pat_nxt = pat_q + LED_BITS'(1);
      MODE_BOUNCE: begin
        if (dir_up_q) begin
          if (pat_q[LED_BITS-1]) begin
            pat_nxt = pat_q >> 1;
            dir_nxt = 1'b0;
          end else begin
            pat_nxt = pat_q << 1;
          end
        end else if (pat_q[0]) begin
          pat_nxt = pat_q << 1;
          dir_nxt = 1'b1;
        end else begin
          pat_nxt = pat_q >> 1;
        end
      end
      MODE_TOGGLE: pat_nxt = ~pat_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    pend_d   = pend_q;
    err_d    = err_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if ((i_start || press) && !i_stop) begin
          mode_d   = mode_e'(i_mode);
          pat_d    = pat_init;
          dir_up_d = 1'b1;
          tmo_d    = '0;
          pend_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (i_wb_ack) begin
          last_d   = pat_q;
          pat_d    = pat_nxt;
          dir_up_d = dir_nxt;
          if (pend_q || stop_ev) begin
            pend_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d   = period_m1;
            state_d = WAIT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (stop_ev) pend_d = 1'b1;
        end
      end
      WAIT: begin
        if (stop_ev) begin
          state_d = IDLE;
        end else if (i_start) begin
          mode_d   = mode_e'(i_mode);
          pat_d    = pat_init;
          dir_up_d = 1'b1;
          tmo_d    = '0;
          state_d  = REQ;
        end else if (cnt_q == '0) begin
          tmo_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_WALK;
      pat_q    <= '0;
      dir_up_q <= 1'b1;
      cnt_q    <= '0;
      tmo_q    <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      dir_up_q <= dir_up_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      last_q   <= last_d;
    end
  end

  assign o_wb_cyc  = (state_q == REQ);
  assign o_wb_stb  = o_wb_cyc;
  assign o_wb_we   = o_wb_cyc;
  assign o_wb_addr = o_wb_cyc ? LED_ADDR : '0;
  assign o_wb_data = 32'(pat_q);
  assign o_running = (state_q != IDLE);
  assign o_err     = err_q;
  assign o_last    = last_q;

endmodule
